// File: rtl/dds_ramp_pkg.sv
// Shared state encoding, command-word layout and width defaults for the
// DDS ramp sequencer.
package dds_ramp_pkg;

   localparam int unsigned FREQ_WIDTH_DEF = 48;
   localparam int unsigned CNT_WIDTH_DEF  = 16;
   localparam int unsigned CMD_WIDTH      = 128;

   localparam int unsigned FSTART_LSB = 80;
   localparam int unsigned FSTART_W   = 48;
   localparam int unsigned FSTEP_LSB  = 32;
   localparam int unsigned FSTEP_W    = 48;
   localparam int unsigned SCOUNT_LSB = 16;
   localparam int unsigned SCOUNT_W   = 16;
   localparam int unsigned SINTV_LSB  = 0;
   localparam int unsigned SINTV_W    = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_e;

endpackage

// File: rtl/ramp_step_timer.sv
// Interval and step counters for one ramp; raises a step strobe every
// effective interval and flags the step that completes the ramp.
module ramp_step_timer #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic [CNT_WIDTH-1:0] interval_i,
   input  logic [CNT_WIDTH-1:0] count_i,
   output logic                 step_o,
   output logic                 last_o
);

   localparam logic [CNT_WIDTH-1:0] ONE_C  = 1;
   localparam logic [CNT_WIDTH:0]   ONE_XC = 1;

   logic [CNT_WIDTH-1:0] intv_q, intv_d;
   logic [CNT_WIDTH-1:0] steps_q, steps_d;
   logic [CNT_WIDTH-1:0] intv_last;

   // An interval of zero behaves like one: a step every cycle.
   assign intv_last = (interval_i == '0) ? '0 : interval_i - ONE_C;
   assign step_o    = en_i && (intv_q == intv_last);
   assign last_o    = step_o && (({1'b0, steps_q} + ONE_XC) == {1'b0, count_i});

   always_comb begin
      intv_d  = intv_q;
      steps_d = steps_q;
      if (clear_i) begin
         intv_d  = '0;
         steps_d = '0;
      end else if (step_o) begin
         intv_d  = '0;
         steps_d = steps_q + ONE_C;
      end else if (en_i) begin
         intv_d  = intv_q + ONE_C;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         intv_q  <= '0;
         steps_q <= '0;
      end else begin
         intv_q  <= intv_d;
         steps_q <= steps_d;
      end
   end

endmodule

// File: rtl/dds_ramp_sequencer.sv
// Frequency ramp sequencer: buffers one command and steps a DDS frequency
// word from freq_start by freq_step, step_count times, every step_interval.
module dds_ramp_sequencer
   import dds_ramp_pkg::*;
#(
   parameter int unsigned FREQ_WIDTH = FREQ_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CMD_WIDTH-1:0]  cmd_data,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  abort,
   output logic [FREQ_WIDTH-1:0] freq,
   output logic                  freq_update,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  wrap_error
);

   state_e                state_q, state_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [CMD_WIDTH-1:0]  pend_cmd_q, pend_cmd_d;
   logic [FREQ_WIDTH-1:0] freq_q, freq_d;
   logic [FREQ_WIDTH-1:0] fstep_q, fstep_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [CNT_WIDTH-1:0]  intv_q, intv_d;
   logic                  upd_q, upd_d;
   logic                  done_q, done_d;
   logic                  aborted_q, aborted_d;
   logic                  wrap_q, wrap_d;

   logic                  handshake, load, step, tmr_step, tmr_last, wrap_now;
   logic [FREQ_WIDTH:0]   sum;
   logic [FREQ_WIDTH-1:0] pend_start, pend_step;
   logic [CNT_WIDTH-1:0]  pend_count, pend_intv;

   assign pend_start = pend_cmd_q[FSTART_LSB +: FREQ_WIDTH];
   assign pend_step  = pend_cmd_q[FSTEP_LSB  +: FREQ_WIDTH];
   assign pend_count = pend_cmd_q[SCOUNT_LSB +: CNT_WIDTH];
   assign pend_intv  = pend_cmd_q[SINTV_LSB  +: CNT_WIDTH];

   assign cmd_ready = !pend_valid_q && !abort;
   assign handshake = cmd_valid && cmd_ready;
   // Holding off the load while done is showing leaves one idle cycle between ramps.
   assign load      = (state_q == ST_IDLE) && pend_valid_q && !done_q && !abort;
   assign step      = tmr_step && !abort;

   // Negative steps wrap on borrow, i.e. when the unsigned add does not carry.
   assign sum       = {1'b0, freq_q} + {1'b0, fstep_q};
   assign wrap_now  = fstep_q[FREQ_WIDTH-1] ? !sum[FREQ_WIDTH] : sum[FREQ_WIDTH];

   ramp_step_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (reset),
      .clear_i    (load || abort),
      .en_i       (state_q == ST_RAMP),
      .interval_i (intv_q),
      .count_i    (count_q),
      .step_o     (tmr_step),
      .last_o     (tmr_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (load) state_d = (pend_count == '0) ? ST_IDLE : ST_RAMP;
            ST_RAMP: if (step && tmr_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_cmd_d   = pend_cmd_q;
      freq_d       = freq_q;
      fstep_d      = fstep_q;
      count_d      = count_q;
      intv_d       = intv_q;
      upd_d        = 1'b0;
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      wrap_d       = wrap_q;
      if (abort) begin
         pend_valid_d = 1'b0;
         aborted_d    = 1'b1;
      end else begin
         if (handshake) begin
            pend_valid_d = 1'b1;
            pend_cmd_d   = cmd_data;
         end
         if (load) begin
            pend_valid_d = 1'b0;
            freq_d       = pend_start;
            fstep_d      = pend_step;
            count_d      = pend_count;
            intv_d       = pend_intv;
            upd_d        = 1'b1;
            wrap_d       = 1'b0;
            done_d       = (pend_count == '0);
         end else if (step) begin
            freq_d = sum[FREQ_WIDTH-1:0];
            upd_d  = 1'b1;
            wrap_d = wrap_q || wrap_now;
            done_d = tmr_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_cmd_q   <= '0;
         freq_q       <= '0;
         fstep_q      <= '0;
         count_q      <= '0;
         intv_q       <= '0;
         upd_q        <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_cmd_q   <= pend_cmd_d;
         freq_q       <= freq_d;
         fstep_q      <= fstep_d;
         count_q      <= count_d;
         intv_q       <= intv_d;
         upd_q        <= upd_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         wrap_q       <= wrap_d;
      end
   end

   assign freq        = freq_q;
   assign freq_update = upd_q;
   assign done        = done_q;
   assign aborted     = aborted_q;
   assign wrap_error  = wrap_q;
   assign busy        = (state_q == ST_RAMP) || pend_valid_q;

endmodule

// File: tb/tb_dds_ramp_sequencer.sv
// Directed bench for dds_ramp_sequencer; cycle offsets are relative to the
// cycle in which the command handshake occurs.
module tb_dds_ramp_sequencer;

   logic         clk;
   logic         reset;
   logic [127:0] cmd_data;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         abort;
   logic [47:0]  freq;
   logic         freq_update;
   logic         busy;
   logic         done;
   logic         aborted;
   logic         wrap_error;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   dds_ramp_sequencer #(
      .FREQ_WIDTH (48),
      .CNT_WIDTH  (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .abort       (abort),
      .freq        (freq),
      .freq_update (freq_update),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .wrap_error  (wrap_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic exp_out(input string tag, input logic [47:0] f, input logic upd, input logic dn);
      check_eq({tag, ".freq"}, {16'h0, freq}, {16'h0, f});
      check_eq({tag, ".upd"},  {63'h0, freq_update}, {63'h0, upd});
      check_eq({tag, ".done"}, {63'h0, done}, {63'h0, dn});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk_cmd(input logic [47:0] start, input logic [47:0] stp,
                                           input logic [15:0] cnt, input logic [15:0] intv);
      return {start, stp, cnt, intv};
   endfunction

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      abort     = 1'b0;
      repeat (3) cyc();
      exp_out("rst", 48'h0, 1'b0, 1'b0);
      check_eq("rst.aborted", {63'h0, aborted}, 64'h0);
      check_eq("rst.wrap",    {63'h0, wrap_error}, 64'h0);
      check_eq("rst.busy",    {63'h0, busy}, 64'h0);
      check_eq("rst.ready",   {63'h0, cmd_ready}, 64'h1);
      reset = 1'b0;

      // Basic ramp: 0x1000 + 3 x 0x10, one step every 2 cycles
      cmd_data  = mk_cmd(48'h1000, 48'h10, 16'd3, 16'd2);
      cmd_valid = 1'b1;
      cyc(); cmd_valid = 1'b0;
      check_eq("s1.busy_pend", {63'h0, busy}, 64'h1);
      #1 check_eq("s1.ready_pend", {63'h0, cmd_ready}, 64'h0);
      cyc(); exp_out("s1.load",  48'h1000, 1'b1, 1'b0);
      cyc(); exp_out("s1.hold0", 48'h1000, 1'b0, 1'b0);
      cyc(); exp_out("s1.step1", 48'h1010, 1'b1, 1'b0);
      cyc(); exp_out("s1.hold1", 48'h1010, 1'b0, 1'b0);
      cyc(); exp_out("s1.step2", 48'h1020, 1'b1, 1'b0);
      cyc(); exp_out("s1.hold2", 48'h1020, 1'b0, 1'b0);
      cyc(); exp_out("s1.step3", 48'h1030, 1'b1, 1'b1);
      cyc(); exp_out("s1.end",   48'h1030, 1'b0, 1'b0);
      check_eq("s1.busy_end", {63'h0, busy}, 64'h0);

      // Zero step count: load and done together
      cmd_data  = mk_cmd(48'hABCD, 48'h0, 16'd0, 16'd5);
      cmd_valid = 1'b1;
      cyc(); cmd_valid = 1'b0;
      cyc(); exp_out("s2.load", 48'hABCD, 1'b1, 1'b1);
      check_eq("s2.busy_load", {63'h0, busy}, 64'h0);
      cyc(); exp_out("s2.after", 48'hABCD, 1'b0, 1'b0);
      check_eq("s2.busy_after", {63'h0, busy}, 64'h0);

      // Back-to-back commands and a stalled third
      cmd_data  = mk_cmd(48'h2000, 48'h1, 16'd2, 16'd1);
      cmd_valid = 1'b1;
      cyc(); cmd_data = mk_cmd(48'h3000, 48'hFFFF_FFFF_FFFF, 16'd1, 16'd3);
      #1 check_eq("s3.ready_t1", {63'h0, cmd_ready}, 64'h0);
      cyc(); exp_out("s3.loadA", 48'h2000, 1'b1, 1'b0);
      check_eq("s3.ready_t2", {63'h0, cmd_ready}, 64'h1);
      cyc(); cmd_data = mk_cmd(48'h5555, 48'h0, 16'd0, 16'd0);
      exp_out("s3.stepA1", 48'h2001, 1'b1, 1'b0);
      #1 check_eq("s3.ready_t3", {63'h0, cmd_ready}, 64'h0);
      cyc(); exp_out("s3.doneA", 48'h2002, 1'b1, 1'b1);
      check_eq("s3.ready_t4", {63'h0, cmd_ready}, 64'h0);
      cyc(); exp_out("s3.idle", 48'h2002, 1'b0, 1'b0);
      check_eq("s3.ready_t5", {63'h0, cmd_ready}, 64'h0);
      check_eq("s3.busy_t5",  {63'h0, busy}, 64'h1);
      cyc(); exp_out("s3.loadB", 48'h3000, 1'b1, 1'b0);
      check_eq("s3.ready_t6", {63'h0, cmd_ready}, 64'h1);
      cyc(); cmd_valid = 1'b0;
      exp_out("s3.hB0", 48'h3000, 1'b0, 1'b0);
      cyc(); exp_out("s3.hB1", 48'h3000, 1'b0, 1'b0);
      cyc(); exp_out("s3.doneB", 48'h2FFF, 1'b1, 1'b1);
      check_eq("s3.wrapB", {63'h0, wrap_error}, 64'h0);
      cyc(); exp_out("s3.idleB", 48'h2FFF, 1'b0, 1'b0);
      cyc(); exp_out("s3.loadC", 48'h5555, 1'b1, 1'b1);

      // Positive wrap through 2^48
      cmd_data  = mk_cmd(48'hFFFF_FFFF_FFF0, 48'h20, 16'd1, 16'd0);
      cmd_valid = 1'b1;
      cyc(); cmd_valid = 1'b0;
      cyc(); exp_out("s4.load", 48'hFFFF_FFFF_FFF0, 1'b1, 1'b0);
      check_eq("s4.wrap_load", {63'h0, wrap_error}, 64'h0);
      cyc(); exp_out("s4.step", 48'h10, 1'b1, 1'b1);
      check_eq("s4.wrap_step", {63'h0, wrap_error}, 64'h1);
      cyc(); cyc();
      check_eq("s4.wrap_sticky", {63'h0, wrap_error}, 64'h1);

      // Abort coinciding with a scheduled step while a command is pending
      cmd_data  = mk_cmd(48'h4000, 48'h100, 16'd4, 16'd2);
      cmd_valid = 1'b1;
      cyc(); cmd_valid = 1'b0;
      cyc(); exp_out("s5.load", 48'h4000, 1'b1, 1'b0);
      check_eq("s5.wrap_clr", {63'h0, wrap_error}, 64'h0);
      cmd_data  = mk_cmd(48'h7777, 48'h1, 16'd1, 16'd1);
      cmd_valid = 1'b1;
      #1 check_eq("s5.ready_pend", {63'h0, cmd_ready}, 64'h1);
      cyc(); cmd_valid = 1'b0;
      check_eq("s5.busy", {63'h0, busy}, 64'h1);
      cyc(); exp_out("s5.step1", 48'h4100, 1'b1, 1'b0);
      cyc(); abort = 1'b1;
      #1 check_eq("s5.ready_abort", {63'h0, cmd_ready}, 64'h0);
      cyc(); abort = 1'b0;
      exp_out("s5.abort", 48'h4100, 1'b0, 1'b0);
      check_eq("s5.aborted",   {63'h0, aborted}, 64'h1);
      check_eq("s5.busy_abrt", {63'h0, busy}, 64'h0);
      #1 check_eq("s5.ready_after", {63'h0, cmd_ready}, 64'h1);
      cyc(); exp_out("s5.post1", 48'h4100, 1'b0, 1'b0);
      check_eq("s5.aborted_clr", {63'h0, aborted}, 64'h0);
      cyc(); exp_out("s5.post2", 48'h4100, 1'b0, 1'b0);
      check_eq("s5.busy_post", {63'h0, busy}, 64'h0);

      // Reset mid-ramp overriding abort and cmd_valid
      cmd_data  = mk_cmd(48'h8000, 48'h1, 16'd5, 16'd1);
      cmd_valid = 1'b1;
      cyc(); cmd_valid = 1'b0;
      cyc(); exp_out("s6.load", 48'h8000, 1'b1, 1'b0);
      cyc(); exp_out("s6.step1", 48'h8001, 1'b1, 1'b0);
      reset     = 1'b1;
      abort     = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = mk_cmd(48'h9999, 48'h1, 16'd1, 16'd1);
      cyc(); reset = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
      exp_out("s6.rst", 48'h0, 1'b0, 1'b0);
      check_eq("s6.rst_aborted", {63'h0, aborted}, 64'h0);
      check_eq("s6.rst_wrap",    {63'h0, wrap_error}, 64'h0);
      check_eq("s6.rst_busy",    {63'h0, busy}, 64'h0);
      #1 check_eq("s6.rst_ready", {63'h0, cmd_ready}, 64'h1);
      cyc();
      exp_out("s6.quiet", 48'h0, 1'b0, 1'b0);
      cmd_data  = mk_cmd(48'h100, 48'h2, 16'd2, 16'd1);
      cmd_valid = 1'b1;
      cyc(); cmd_valid = 1'b0;
      cyc(); exp_out("s6.load2", 48'h100, 1'b1, 1'b0);
      cyc(); exp_out("s6.step2a", 48'h102, 1'b1, 1'b0);
      cyc(); exp_out("s6.step2b", 48'h104, 1'b1, 1'b1);
      cyc(); check_eq("s6.busy_end", {63'h0, busy}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dds_ramp_sequencer.md
DDS_RAMP_SEQUENCER -- requirements
Module: dds_ramp_sequencer

Interface
REQ-001 Parameter FREQ_WIDTH, default 48, frequency word width matching the DDS frequency input.
REQ-002 Parameter CNT_WIDTH, default 16, width of step_count and step_interval fields.
REQ-003 Port clk  input  1  single clock for the entire block; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port cmd_data  input  128  command: [127:80] freq_start, [79:32] freq_step (signed two's complement), [31:16] step_count, [15:0] step_interval.
REQ-006 Port cmd_valid  input  1  command present.
REQ-007 Port cmd_ready  output  1  command buffer free.
REQ-008 Port abort  input  1  single-cycle request to terminate the active ramp and drop any pending command.
REQ-009 Port freq  output  FREQ_WIDTH  frequency word to the DDS.
REQ-010 Port freq_update  output  1  one-cycle pulse whenever freq changes.
REQ-011 Port busy  output  1  high while state is RAMP or the command buffer is occupied.
REQ-012 Port done  output  1  one-cycle pulse on ramp completion.
REQ-013 Port aborted  output  1  one-cycle pulse acknowledging abort.
REQ-014 Port wrap_error  output  1  sticky flag: a frequency step wrapped past 0 or 2^FREQ_WIDTH-1.

Function
REQ-015 One-deep command buffer; cmd_ready = !pend_valid && !abort; handshake when cmd_valid && cmd_ready.
REQ-016 Handshake in cycle t sets pend_valid at edge ending t; FSM may consume the buffer in cycle t+1.
REQ-017 States: IDLE, RAMP (encoded in package enum).
REQ-018 IDLE with pend_valid: consume the buffer (pend_valid cleared), load freq=freq_start, pulse freq_update, clear wrap_error; freq is therefore visible 2 cycles after handshake.
REQ-019 On load, step_count == 0: pulse done in the same cycle as freq_update and remain in IDLE; otherwise go to RAMP with interval counter = 0 and step counter = 0.
REQ-020 step_interval == 0 is treated as 1 (a step every cycle).
REQ-021 In RAMP, the interval counter increments each cycle; when it reaches step_interval-1 (effective), it resets to 0, freq <= freq + freq_step (mod 2^FREQ_WIDTH), freq_update pulses, and the step counter increments.
REQ-022 The step that makes the step counter equal step_count also pulses done in that cycle and returns the FSM to IDLE.
REQ-023 Exactly step_count updates after the load; the final freq = freq_start + step_count*freq_step mod 2^FREQ_WIDTH.
REQ-024 A pending command after done is consumed in the following IDLE cycle (exactly one idle cycle between ramps).
REQ-025 wrap_error sets when a positive step produces a carry out or a negative step produces a borrow; it is held until reset or the next load.
REQ-026 abort (any state): next state IDLE, pend_valid cleared, freq held, no done and no freq_update, aborted pulses next cycle; abort takes priority over a coincident step, load or handshake.
REQ-027 freq_update, done and aborted are registered outputs; freq holds its value between updates.

Reset
REQ-028 Reset state: state IDLE, pend_valid 0, freq 0, all counters 0, freq_update/done/aborted 0, wrap_error 0, busy 0.
REQ-029 Reset mid-ramp: the ramp terminates without done/aborted; reset overrides abort and cmd_valid.

Structure
REQ-030 A shared package dds_ramp_pkg holds the state enum, the cmd field bit offsets and widths, and the FREQ_WIDTH/CNT_WIDTH defaults.
REQ-031 One sub-module, ramp_step_timer (interval counter, step counter, step and last-step strobes), is instantiated; the command buffer, adder and FSM stay in the top.

Verification
REQ-032 Reset; cmd freq_start=0x1000, step=+0x10, count=3, interval=2 -> freq 0x1000 at t+2, then 0x1010/0x1020/0x1030 every 2 cycles; done coincides with 0x1030.
REQ-033 count=0, freq_start=0xABCD -> single freq_update to 0xABCD, done in the same cycle, busy low the next cycle.
REQ-034 Second cmd issued during a ramp -> cmd_ready drops until the first ramp's load; second load occurs exactly 2 cycles after the first done; third cmd stalls.
REQ-035 freq_start=0xFFFF_FFFF_FFF0, step=+0x20, count=1, interval=0 -> freq 0x10 one cycle after load, wrap_error=1 until next load.
REQ-036 abort on the same cycle as a scheduled step plus a pending cmd -> freq unchanged, no done, aborted pulse next cycle, pend dropped, cmd_ready high afterward.
REQ-037 Reset asserted mid-ramp -> all outputs at reset values the next cycle; a subsequent cmd runs normally.
